ahb_cmd_master: RTL

AHB_CMD_MASTER -- requirements
Module: ahb_cmd_master

---
 rtl/ahb_master_pkg.sv | 29 ++
 rtl/cmd_fifo.sv | 50 +++++
 rtl/ahb_cmd_master.sv | 122 ++++++++++++
 3 files changed

// File: rtl/ahb_master_pkg.sv
// ahb_master_pkg: AHB-lite encodings, FSM states and the queued command layout
// shared by the command master and its FIFO.
package ahb_master_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10
    } state_e;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: command queue for the AHB master; pointers carry an extra wrap bit
// so full and empty are distinguishable without a separate counter.
module cmd_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             do_push, do_pop;

    assign empty   = wptr_q == rptr_q;
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = do_push ? wptr_q + 1'b1 : wptr_q;
        rptr_d = do_pop ? rptr_q + 1'b1 : rptr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage carries no reset: only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/ahb_cmd_master.sv
// ahb_cmd_master: queues host commands and runs them one at a time as single
// AHB-lite word transfers, returning one response per command in order.
module ahb_cmd_master
    import ahb_master_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [3:0] HPROT_VAL  = 4'b0011
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        M_HSEL,
    output logic [31:0] M_HADDR,
    output logic [2:0]  M_HBURST,
    output logic [1:0]  M_HTRANS,
    output logic [2:0]  M_HSIZE,
    output logic        M_HWRITE,
    output logic [31:0] M_HWDATA,
    output logic [3:0]  M_HPROT,
    input  logic        M_HREADY,
    input  logic [31:0] M_HRDATA,
    input  logic        M_HRESP,
    output logic        busy
);

    state_e      state_q, state_d;
    cmd_t        head;
    logic        fifo_full, fifo_empty;
    logic        start, addr_done, data_done;
    logic        hsel_q, hsel_d;
    htrans_e     htrans_q, htrans_d;
    logic [31:0] haddr_q, haddr_d;
    logic        hwrite_q, hwrite_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (HCLK),
        .rst     (HRESET),
        .push    (cmd_valid && cmd_ready),
        .pop     (data_done),
        .wr_data ({cmd_write, cmd_addr, cmd_wdata}),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign cmd_ready = !fifo_full && !HRESET;
    // A new transfer starts only once the previous response is gone or leaving now.
    assign start     = state_q == ST_IDLE && !fifo_empty && (!rsp_valid_q || rsp_ready);
    assign addr_done = state_q == ST_ADDR && M_HREADY;
    assign data_done = state_q == ST_DATA && M_HREADY;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = start ? ST_ADDR : addr_done ? ST_DATA : data_done ? ST_IDLE : state_q;
    end

    always_comb begin
        hsel_d      = start ? 1'b1 : addr_done ? 1'b0 : hsel_q;
        htrans_d    = start ? HTRANS_NONSEQ : addr_done ? HTRANS_IDLE : htrans_q;
        haddr_d     = start ? head.addr & 32'hFFFF_FFFC : haddr_q;
        hwrite_d    = start ? head.write : hwrite_q;
        hwdata_d    = (addr_done && hwrite_q) ? head.wdata : hwdata_q;
        rsp_valid_d = data_done || (rsp_valid_q && !rsp_ready);
        rsp_rdata_d = data_done ? (hwrite_q ? 32'h0 : M_HRDATA) : rsp_rdata_q;
        rsp_err_d   = data_done ? M_HRESP : rsp_err_q;
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            hsel_q      <= 1'b0;
            htrans_q    <= HTRANS_IDLE;
            haddr_q     <= '0;
            hwrite_q    <= 1'b0;
            hwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            hsel_q      <= hsel_d;
            htrans_q    <= htrans_d;
            haddr_q     <= haddr_d;
            hwrite_q    <= hwrite_d;
            hwdata_q    <= hwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign M_HSEL    = hsel_q;
    assign M_HTRANS  = htrans_q;
    assign M_HADDR   = haddr_q;
    assign M_HWRITE  = hwrite_q;
    assign M_HWDATA  = hwdata_q;
    assign M_HSIZE   = HSIZE_WORD;
    assign M_HBURST  = HBURST_SINGLE;
    assign M_HPROT   = HPROT_VAL;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = state_q != ST_IDLE || !fifo_empty;

endmodule
